// File: rtl/unified_mem_arbiter_pkg.sv
// Shared constants for the unified memory arbiter.
// State encoding, grant ids and parameter defaults.
package unified_mem_arbiter_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int DATA_W_DEF  = 32;
  localparam int TIMEOUT_DEF = 255;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] IF_BUSY = 2'd1;
  localparam logic [1:0] D_BUSY  = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_D  = 1'b1;

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// Fetch, data and memory bus bundle of the arbiter.
// master: arbiter side; slave: requesters and memory.
interface unified_mem_arbiter_if
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ready;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  modport master (
    input  if_req, if_addr,
    input  d_read, d_write, d_addr, d_wdata,
    input  mem_rdata, mem_ack,
    output if_rdata, if_ready,
    output d_rdata, d_ready,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr,
    output d_read, d_write, d_addr, d_wdata,
    output mem_rdata, mem_ack,
    input  if_rdata, if_ready,
    input  d_rdata, d_ready,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/unified_mem_arbiter_ack_timeout_counter.sv
// 8-bit busy-cycle counter; tc flags the last cycle
// before the acknowledge timeout. Ports: clk, rst, clr, en, tc.
module unified_mem_arbiter_ack_timeout_counter #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 8'd0;
    end else if (clr) begin
      count <= 8'd0;
    end else if (en) begin
      count <= count + 8'd1;
    end
  end

  // tc is high in the busy cycle that completes LIMIT cycles
  assign tc = (count == LIMIT - 8'd1);

endmodule

// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter sharing one memory between fetch and data.
// Ports: clk, rst, bus (master), stall_fetch, stall_pipe, bus_err.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst,
  unified_mem_arbiter_if.master bus,
  output logic stall_fetch,
  output logic stall_pipe,
  output logic bus_err
);

  logic [1:0]        state;
  logic              last_grant;
  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              if_ready_q;
  logic              d_ready_q;
  logic              err_q;

  logic d_elig;
  logic f_elig;
  logic pick_d;
  logic busy;
  logic tc;

  assign d_elig = bus.d_read | bus.d_write;
  assign f_elig = bus.if_req;
  // data wins if alone, or if fetch was served last
  assign pick_d = d_elig &
    (~f_elig | (last_grant == GRANT_IF));
  assign busy = (state == IF_BUSY) |
    (state == D_BUSY);

  unified_mem_arbiter_ack_timeout_counter #(
    .LIMIT(8'(TIMEOUT_CYC))
  ) u_tmo (
    .clk(clk),
    .rst(rst),
    .clr(state == IDLE),
    .en (busy & ~bus.mem_ack),
    .tc (tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= GRANT_D;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (d_elig | f_elig) begin
            state      <= pick_d ? D_BUSY : IF_BUSY;
            last_grant <= pick_d ? GRANT_D : GRANT_IF;
            req_q      <= 1'b1;
            we_q       <= pick_d & bus.d_write;
            addr_q     <= pick_d ? bus.d_addr
                                 : bus.if_addr;
            wdata_q    <= pick_d ? bus.d_wdata : '0;
          end
        end
        IF_BUSY, D_BUSY: begin
          // ack wins over a coincident timeout
          if (bus.mem_ack || tc) begin
            req_q <= 1'b0;
            state <= DONE;
            if (!bus.mem_ack) err_q <= 1'b1;
            if (state == D_BUSY) begin
              d_ready_q <= 1'b1;
              d_rdata_q <= bus.mem_ack ?
                bus.mem_rdata : '0;
            end else begin
              if_ready_q <= 1'b1;
              if_rdata_q <= bus.mem_ack ?
                bus.mem_rdata : '0;
            end
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ready   = d_ready_q;
  assign bus_err       = err_q;

  assign stall_fetch = bus.if_req & ~if_ready_q;
  assign stall_pipe  = d_elig & ~d_ready_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: directed cycle checks
// plus random traffic against a queue-based scoreboard.
module tb_unified_mem_arbiter;
  import unified_mem_arbiter_pkg::*;

  localparam int TMO = 4;
  localparam int NEVER = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall_fetch;
  logic stall_pipe;
  logic bus_err;

  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  unified_mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .stall_fetch(stall_fetch),
    .stall_pipe(stall_pipe),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          chk;
    bit          tmo;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          k;
  } txn_t;

  exp_t if_exp_q[$];
  exp_t d_exp_q[$];
  txn_t if_txn_q[$];
  txn_t d_txn_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];

  int n_tests = 0;
  int n_fail = 0;
  bit err_model = 0;
  bit rand_mode = 0;
  int dir_k = 0;
  int txn_count = 0;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h3C3C_0000;
  endfunction

  task automatic chk1(input string nm,
                      input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b required %0b",
               nm, act, exp);
    end
  endtask

  task automatic chk32(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h",
               nm, act, exp);
    end
  endtask

  // memory model: wait k cycles then ack
  bit          m_active = 0;
  int          m_waited = 0;
  int          m_k = 0;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_we;
  txn_t        m_t;

  initial begin
    bus.mem_ack = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!bus.mem_req) begin
        m_active = 0;
        bus.mem_ack = 1'b0;
      end else begin
        if (!m_active) begin
          m_active = 1;
          m_waited = 0;
          txn_count++;
          m_addr = bus.mem_addr;
          m_wdata = bus.mem_wdata;
          m_we = bus.mem_we;
          m_k = dir_k;
          if (rand_mode) begin
            if (m_addr[28] && d_txn_q.size() > 0)
              m_t = d_txn_q.pop_front();
            else if (!m_addr[28] && if_txn_q.size() > 0)
              m_t = if_txn_q.pop_front();
            else begin
              m_t.we = m_we;
              m_t.addr = 32'hFFFF_FFFF;
              m_t.wdata = m_wdata;
              m_t.k = 0;
            end
            chk1("mem_we", m_we, m_t.we);
            chk32("mem_addr", m_addr, m_t.addr);
            if (m_t.we)
              chk32("mem_wdata", m_wdata, m_t.wdata);
            m_k = m_t.k;
          end
        end else begin
          chk1("mem_we_hold", bus.mem_we, m_we);
          chk32("mem_addr_hold", bus.mem_addr, m_addr);
          chk32("mem_wdata_hold", bus.mem_wdata, m_wdata);
        end
        if (m_waited == m_k) begin
          bus.mem_ack = 1'b1;
          if (m_we) begin
            mem[m_addr] = m_wdata;
            bus.mem_rdata = '0;
          end else begin
            bus.mem_rdata = mem.exists(m_addr) ?
              mem[m_addr] : dflt(m_addr);
          end
        end else begin
          bus.mem_ack = 1'b0;
          m_waited++;
        end
      end
    end
  end

  // scoreboard monitor
  exp_t e_if;
  exp_t e_d;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk1("stall_fetch", stall_fetch,
             bus.if_req & ~bus.if_ready);
        chk1("stall_pipe", stall_pipe,
             (bus.d_read | bus.d_write) & ~bus.d_ready);
        if (bus.if_ready) begin
          if (if_exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL if_ready: got pulse required none");
          end else begin
            e_if = if_exp_q.pop_front();
            if (e_if.tmo) err_model = 1;
            if (e_if.chk)
              chk32("if_rdata", bus.if_rdata, e_if.data);
            chk1("bus_err_if", bus_err, err_model);
          end
        end
        if (bus.d_ready) begin
          if (d_exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL d_ready: got pulse required none");
          end else begin
            e_d = d_exp_q.pop_front();
            if (e_d.tmo) err_model = 1;
            if (e_d.chk)
              chk32("d_rdata", bus.d_rdata, e_d.data);
            chk1("bus_err_d", bus_err, err_model);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.d_read = 1'b0;
    bus.d_write = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    if_exp_q.delete();
    d_exp_q.delete();
    err_model = 0;
    repeat (2) @(posedge clk);
    #1;
    chk1("rst_mem_req", bus.mem_req, 1'b0);
    chk1("rst_mem_we", bus.mem_we, 1'b0);
    chk32("rst_mem_addr", bus.mem_addr, 32'h0);
    chk32("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk32("rst_if_rdata", bus.if_rdata, 32'h0);
    chk32("rst_d_rdata", bus.d_rdata, 32'h0);
    chk1("rst_if_ready", bus.if_ready, 1'b0);
    chk1("rst_d_ready", bus.d_ready, 1'b0);
    chk1("rst_bus_err", bus_err, 1'b0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_rdy(input bit dport);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(dport ? bus.d_ready : bus.if_ready)
               && t < 40);
    chk1(dport ? "d_ready_seen" : "if_ready_seen",
         dport ? bus.d_ready : bus.if_ready, 1'b1);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic f_drv(input int n);
    for (int i = 0; i < n; i++) begin
      logic [31:0] a;
      int k;
      exp_t e;
      txn_t t;
      a = 32'h100 + 32'($urandom_range(0, 15)) * 4;
      k = ($urandom_range(0, 7) == 0) ? NEVER
          : int'($urandom_range(0, 3));
      e.chk = 1;
      e.tmo = (k >= TMO);
      e.data = e.tmo ? 32'h0 : dflt(a);
      t.we = 0;
      t.addr = a;
      t.wdata = '0;
      t.k = k;
      if_exp_q.push_back(e);
      if_txn_q.push_back(t);
      bus.if_req = 1'b1;
      bus.if_addr = a;
      wait_rdy(1'b0);
      next_cyc();
      bus.if_req = 1'b0;
      repeat ($urandom_range(0, 2)) next_cyc();
    end
  endtask

  task automatic d_drv(input int n);
    for (int i = 0; i < n; i++) begin
      int op;
      int k;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rv;
      bit we;
      exp_t e;
      txn_t t;
      op = int'($urandom_range(0, 3));
      we = (op >= 2);
      a = 32'h1000_0000 + 32'($urandom_range(0, 7)) * 4;
      wd = $urandom;
      k = ($urandom_range(0, 7) == 0) ? NEVER
          : int'($urandom_range(0, 3));
      e.tmo = (k >= TMO);
      rv = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
      if (we && !e.tmo) ref_mem[a] = wd;
      e.chk = !we || e.tmo;
      e.data = e.tmo ? 32'h0 : rv;
      t.we = we;
      t.addr = a;
      t.wdata = wd;
      t.k = k;
      d_exp_q.push_back(e);
      d_txn_q.push_back(t);
      bus.d_read = (op != 2);
      bus.d_write = we;
      bus.d_addr = a;
      bus.d_wdata = wd;
      wait_rdy(1'b1);
      next_cyc();
      bus.d_read = 1'b0;
      bus.d_write = 1'b0;
      repeat ($urandom_range(0, 2)) next_cyc();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    mem[32'h8] = 32'h8C01_0004;
    #1;
    do_reset();

    // lone fetch, zero wait
    dir_k = 0;
    next_cyc();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h8;
    if_exp_q.push_back('{1, 0, 32'h8C01_0004});
    for (int c = 0; c < 4; c++) begin
      if (c > 0) next_cyc();
      if (c == 3) bus.if_req = 1'b0;
      @(negedge clk);
      chk1("lf_req", bus.mem_req, c == 1);
      chk1("lf_stall", stall_fetch, c < 2);
      chk1("lf_ready", bus.if_ready, c == 2);
      if (c == 1) chk32("lf_addr", bus.mem_addr, 32'h8);
    end

    // simultaneous after reset: fetch first
    do_reset();
    next_cyc();
    bus.if_req = 1'b1;
    bus.if_addr = 32'h10;
    bus.d_read = 1'b1;
    bus.d_addr = 32'h44;
    if_exp_q.push_back('{1, 0, dflt(32'h10)});
    d_exp_q.push_back('{1, 0, dflt(32'h44)});
    for (int c = 0; c < 7; c++) begin
      if (c > 0) next_cyc();
      if (c == 3) bus.if_req = 1'b0;
      if (c == 6) bus.d_read = 1'b0;
      @(negedge clk);
      chk1("sim_req", bus.mem_req, c == 1 || c == 4);
      if (c == 1) chk32("sim_addr_if", bus.mem_addr, 32'h10);
      if (c == 4) chk32("sim_addr_d", bus.mem_addr, 32'h44);
      chk1("sim_if_ready", bus.if_ready, c == 2);
      chk1("sim_d_ready", bus.d_ready, c == 5);
    end

    // store with 3 wait states
    dir_k = 3;
    next_cyc();
    bus.d_write = 1'b1;
    bus.d_addr = 32'h40;
    bus.d_wdata = 32'h1234_5678;
    d_exp_q.push_back('{0, 0, 32'h0});
    for (int c = 0; c < 7; c++) begin
      if (c > 0) next_cyc();
      if (c == 6) bus.d_write = 1'b0;
      @(negedge clk);
      chk1("st_req", bus.mem_req, c >= 1 && c <= 4);
      if (c >= 1 && c <= 4) begin
        chk1("st_we", bus.mem_we, 1'b1);
        chk32("st_addr", bus.mem_addr, 32'h40);
        chk32("st_wdata", bus.mem_wdata, 32'h1234_5678);
      end
      chk1("st_stall", stall_pipe, c <= 4);
      chk1("st_ready", bus.d_ready, c == 5);
    end

    // request held through DONE issues once
    dir_k = 1;
    base = txn_count;
    next_cyc();
    bus.d_read = 1'b1;
    bus.d_addr = 32'h40;
    d_exp_q.push_back('{1, 0, 32'h1234_5678});
    wait_rdy(1'b1);
    next_cyc();
    bus.d_read = 1'b0;
    repeat (4) next_cyc();
    @(negedge clk);
    chk32("held_txns", 32'(txn_count - base), 32'd1);

    // acknowledge timeout
    dir_k = NEVER;
    next_cyc();
    bus.d_read = 1'b1;
    bus.d_addr = 32'h80;
    d_exp_q.push_back('{1, 1, 32'h0});
    for (int c = 0; c < 9; c++) begin
      if (c > 0) next_cyc();
      if (c == 6) bus.d_read = 1'b0;
      @(negedge clk);
      chk1("to_req", bus.mem_req, c >= 1 && c <= 4);
      chk1("to_ready", bus.d_ready, c == 5);
      chk1("to_err", bus_err, c >= 5);
    end

    // reset mid-transaction
    next_cyc();
    bus.d_read = 1'b1;
    bus.d_addr = 32'h84;
    d_exp_q.push_back('{1, 1, 32'h0});
    for (int c = 0; c < 3; c++) begin
      if (c > 0) next_cyc();
      @(negedge clk);
    end
    chk1("mid_req_busy", bus.mem_req, 1'b1);
    rst = 1'b0;
    #1;
    chk1("mid_req_drop", bus.mem_req, 1'b0);
    chk1("mid_err_clr", bus_err, 1'b0);
    do_reset();
    dir_k = 0;
    next_cyc();
    bus.d_read = 1'b1;
    bus.d_addr = 32'h84;
    d_exp_q.push_back('{1, 0, dflt(32'h84)});
    for (int c = 0; c < 4; c++) begin
      if (c > 0) next_cyc();
      if (c == 3) bus.d_read = 1'b0;
      @(negedge clk);
      chk1("post_req", bus.mem_req, c == 1);
      chk1("post_ready", bus.d_ready, c == 2);
    end

    // random concurrent traffic
    rand_mode = 1;
    fork
      f_drv(40);
      d_drv(40);
    join
    repeat (4) next_cyc();
    @(negedge clk);
    chk32("if_left", 32'(if_exp_q.size()), 32'd0);
    chk32("d_left", 32'(d_exp_q.size()), 32'd0);
    chk32("if_txn_left", 32'(if_txn_q.size()), 32'd0);
    chk32("d_txn_left", 32'(d_txn_q.size()), 32'd0);
    chk1("final_err", bus_err, err_model);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
